// File: rtl/io_bus_arbiter_pkg.sv
// io_bus_arbiter_pkg: shared types and constants for the two-master register-bus arbiter.
package io_bus_arbiter_pkg;

    localparam int NOS_BUS_MASTERS     = 2;
    localparam int BUS_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RELEASE} arb_state_t;

    typedef logic [0:0] master_id_t;

    function automatic master_id_t other_master(input master_id_t id);
        return master_id_t'(~id);
    endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// io_bus_arbiter_if: master-side handshake and slave-side register bus bundled together.
interface io_bus_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    import io_bus_arbiter_pkg::*;

    logic [NOS_BUS_MASTERS-1:0]             m_req;
    logic [NOS_BUS_MASTERS-1:0]             m_rw;
    logic [NOS_BUS_MASTERS-1:0][ADDR_W-1:0] m_addr;
    logic [NOS_BUS_MASTERS-1:0][DATA_W-1:0] m_wdata;
    logic [NOS_BUS_MASTERS-1:0]             m_ack;
    logic [NOS_BUS_MASTERS-1:0]             m_err;
    logic [DATA_W-1:0]                      m_rdata;
    logic                                   bus_valid;
    logic                                   bus_rw;
    logic [ADDR_W-1:0]                      bus_addr;
    logic [DATA_W-1:0]                      bus_wdata;
    logic                                   bus_ack;
    logic [DATA_W-1:0]                      bus_rdata;

    // slave: the arbiter's view; master: the requesters and slave stubs around it
    modport slave (
        input  m_req, m_rw, m_addr, m_wdata, bus_ack, bus_rdata,
        output m_ack, m_err, m_rdata, bus_valid, bus_rw, bus_addr, bus_wdata
    );

    modport master (
        output m_req, m_rw, m_addr, m_wdata, bus_ack, bus_rdata,
        input  m_ack, m_err, m_rdata, bus_valid, bus_rw, bus_addr, bus_wdata
    );

endinterface

// File: rtl/io_bus_arbiter_rr_select.sv
// io_bus_arbiter_rr_select: 2-way round-robin / fixed-priority chooser with its own priority pointer.
module io_bus_arbiter_rr_select
    import io_bus_arbiter_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NOS_BUS_MASTERS-1:0] req,
    input  master_id_t                 last,
    input  logic                       adv,
    input  logic                       fixed,
    output master_id_t                 grant_id,
    output logic                       any
);

    master_id_t ptr;

    // ptr names the master that wins the next tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (adv)
            ptr <= other_master(last);
    end

    assign any      = |req;
    assign grant_id = &req ? (fixed ? master_id_t'(1'b0) : ptr) : master_id_t'(req[1]);

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the register bus between the uP and the motion sequencer,
// with 4-phase handshakes toward the masters and a bus-ack timeout watchdog.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic             clk,
    input  logic             reset,
    io_bus_arbiter_if.slave  io,
    output master_id_t       owner
);

    arb_state_t                 state, state_nxt;
    logic [15:0]                cnt;
    master_id_t                 grant_id;
    logic                       any;
    logic                       timeout;
    logic                       done;
    logic                       bus_valid_q;
    logic                       bus_rw_q;
    logic [ADDR_W-1:0]          bus_addr_q;
    logic [DATA_W-1:0]          bus_wdata_q;
    logic [NOS_BUS_MASTERS-1:0] m_ack_q;
    logic [NOS_BUS_MASTERS-1:0] m_err_q;
    logic [DATA_W-1:0]          m_rdata_q;

    assign timeout      = cnt == 16'(TIMEOUT_CYCLES - 1);
    assign done         = !io.m_req[owner];
    assign io.bus_valid = bus_valid_q;
    assign io.bus_rw    = bus_rw_q;
    assign io.bus_addr  = bus_addr_q;
    assign io.bus_wdata = bus_wdata_q;
    assign io.m_ack     = m_ack_q;
    assign io.m_err     = m_err_q;
    assign io.m_rdata   = m_rdata_q;

    io_bus_arbiter_rr_select u_sel (
        .clk      (clk),
        .reset    (reset),
        .req      (io.m_req),
        .last     (owner),
        .adv      (state == RELEASE && done),
        .fixed    (FIXED_PRIORITY != 0),
        .grant_id (grant_id),
        .any      (any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = any ? ISSUE : IDLE;
            ISSUE:    state_nxt = WAIT_ACK;
            WAIT_ACK: state_nxt = (io.bus_ack || timeout) ? RELEASE : WAIT_ACK;
            RELEASE:  state_nxt = done ? IDLE : RELEASE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner       <= '0;
            cnt         <= '0;
            bus_valid_q <= 1'b0;
            bus_rw_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            m_ack_q     <= '0;
            m_err_q     <= '0;
            m_rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    owner       <= grant_id;
                    bus_rw_q    <= io.m_rw[grant_id];
                    bus_addr_q  <= io.m_addr[grant_id];
                    bus_wdata_q <= io.m_wdata[grant_id];
                end
                ISSUE: begin
                    bus_valid_q <= 1'b1;
                    cnt         <= '0;
                end
                WAIT_ACK: begin
                    cnt <= cnt + 16'd1;
                    // a late ack on the timeout cycle still counts as success
                    if (io.bus_ack || timeout) begin
                        bus_valid_q    <= 1'b0;
                        m_ack_q[owner] <= 1'b1;
                        m_err_q[owner] <= !io.bus_ack;
                        m_rdata_q      <= io.bus_ack ? io.bus_rdata : '0;
                    end
                end
                RELEASE: if (done) begin
                    m_ack_q <= '0;
                    m_err_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed checks of a round-robin and a fixed-priority arbiter instance.
module tb_io_bus_arbiter;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sel = 1'b0;
    logic [1:0]       req = '0;
    logic [1:0]       rw = '0;
    logic [1:0][7:0]  addr = '0;
    logic [1:0][31:0] wdata = '0;
    logic             back = 1'b0;
    logic [31:0]      brdata = '0;
    logic             own_a, own_b;
    logic [1:0]       ack, err;
    logic [31:0]      rdata, bwdata;
    logic [7:0]       baddr;
    logic             bvalid, brw, own;
    int               checks = 0;
    int               failures = 0;

    always #5 clk = ~clk;

    io_bus_arbiter_if #(.ADDR_W(8), .DATA_W(32)) ia ();
    io_bus_arbiter_if #(.ADDR_W(8), .DATA_W(32)) ib ();

    assign ia.m_req     = sel ? 2'b00 : req;
    assign ib.m_req     = sel ? req : 2'b00;
    assign ia.m_rw      = rw;
    assign ib.m_rw      = rw;
    assign ia.m_addr    = addr;
    assign ib.m_addr    = addr;
    assign ia.m_wdata   = wdata;
    assign ib.m_wdata   = wdata;
    assign ia.bus_ack   = back;
    assign ib.bus_ack   = back;
    assign ia.bus_rdata = brdata;
    assign ib.bus_rdata = brdata;

    assign ack    = sel ? ib.m_ack : ia.m_ack;
    assign err    = sel ? ib.m_err : ia.m_err;
    assign rdata  = sel ? ib.m_rdata : ia.m_rdata;
    assign bvalid = sel ? ib.bus_valid : ia.bus_valid;
    assign brw    = sel ? ib.bus_rw : ia.bus_rw;
    assign baddr  = sel ? ib.bus_addr : ia.bus_addr;
    assign bwdata = sel ? ib.bus_wdata : ia.bus_wdata;
    assign own    = sel ? own_b : own_a;

    io_bus_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(10), .FIXED_PRIORITY(0)) dut_rr (
        .clk(clk), .reset(reset), .io(ia), .owner(own_a));

    io_bus_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(10), .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset(reset), .io(ib), .owner(own_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input int m, input logic r, input logic [7:0] a, input logic [31:0] d);
        req[m] = 1'b1;
        rw[m] = r;
        addr[m] = a;
        wdata[m] = d;
        step(2);
    endtask

    task automatic ack_bus(input logic [31:0] d);
        back = 1'b1;
        brdata = d;
        step(1);
        back = 1'b0;
    endtask

    initial begin
        step(2);
        chk("rst_valid", 32'(bvalid), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_owner", 32'(own), 32'd0);
        reset = 1'b0;
        // write from master 0
        req[0] = 1'b1; rw[0] = 1'b0; addr[0] = 8'h12; wdata[0] = 32'hDEADBEEF;
        step(1);
        chk("wr_issue_novalid", 32'(bvalid), 32'd0);
        step(1);
        chk("wr_valid", 32'(bvalid), 32'd1);
        chk("wr_addr", 32'(baddr), 32'h12);
        chk("wr_wdata", bwdata, 32'hDEADBEEF);
        chk("wr_rw", 32'(brw), 32'd0);
        step(2);
        chk("wr_stable", bwdata, 32'hDEADBEEF);
        ack_bus(32'h0);
        chk("wr_ack", 32'(ack), 32'h1);
        chk("wr_err", 32'(err), 32'h0);
        chk("wr_valid_off", 32'(bvalid), 32'd0);
        step(2);
        chk("wr_ack_hold", 32'(ack), 32'h1);
        req[0] = 1'b0;
        step(1);
        chk("wr_ack_drop", 32'(ack), 32'h0);
        // read from master 1
        issue(1, 1'b1, 8'h05, 32'h0);
        chk("rd_owner", 32'(own), 32'd1);
        chk("rd_addr", 32'(baddr), 32'h05);
        chk("rd_rw", 32'(brw), 32'd1);
        ack_bus(32'h0000_1234);
        chk("rd_rdata", rdata, 32'h0000_1234);
        chk("rd_ack", 32'(ack), 32'h2);
        req[1] = 1'b0;
        step(1);
        chk("rd_ack_drop", 32'(ack), 32'h0);
        // round-robin ties alternate
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step(2);
            chk("rr_owner", 32'(own), 32'(i % 2));
            ack_bus(32'hA0 + 32'(i));
            chk("rr_ack", 32'(ack), 32'd1 << (i % 2));
            req[i % 2] = 1'b0;
            step(1);
            req[i % 2] = 1'b1;
        end
        req = 2'b00;
        // timeout
        issue(0, 1'b1, 8'h33, 32'h0);
        chk("to_valid", 32'(bvalid), 32'd1);
        step(9);
        chk("to_still_valid", 32'(bvalid), 32'd1);
        step(1);
        chk("to_valid_off", 32'(bvalid), 32'd0);
        chk("to_ack", 32'(ack), 32'h1);
        chk("to_err", 32'(err), 32'h1);
        chk("to_rdata", rdata, 32'h0);
        req[0] = 1'b0;
        step(1);
        chk("to_err_drop", 32'(err), 32'h0);
        // ack on the timeout cycle
        issue(1, 1'b1, 8'h44, 32'h0);
        step(9);
        ack_bus(32'h0000_CAFE);
        chk("ackto_ack", 32'(ack), 32'h2);
        chk("ackto_err", 32'(err), 32'h0);
        chk("ackto_rdata", rdata, 32'h0000_CAFE);
        req[1] = 1'b0;
        step(1);
        // owner drops request early: one-cycle ack pulse
        issue(0, 1'b0, 8'h55, 32'h1);
        req[0] = 1'b0;
        step(1);
        chk("pv_valid", 32'(bvalid), 32'd1);
        ack_bus(32'h0);
        chk("pv_ack", 32'(ack), 32'h1);
        step(1);
        chk("pv_ack_pulse", 32'(ack), 32'h0);
        // reset during WAIT_ACK, pointer restarts at master 0
        req = 2'b11;
        step(2);
        chk("rst_mid_owner", 32'(own), 32'd1);
        chk("rst_mid_valid", 32'(bvalid), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_valid", 32'(bvalid), 32'd0);
        chk("rst_async_ack", 32'(ack), 32'h0);
        chk("rst_async_owner", 32'(own), 32'd0);
        step(1);
        reset = 1'b0;
        step(2);
        chk("rst_rearb_owner", 32'(own), 32'd0);
        chk("rst_rearb_valid", 32'(bvalid), 32'd1);
        ack_bus(32'h0);
        req = 2'b00;
        step(1);
        // fixed priority instance
        sel = 1'b1;
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step(2);
            chk("fp_owner0", 32'(own), 32'd0);
            ack_bus(32'h0);
            req[0] = 1'b0;
            step(1);
            if (i < 2) req[0] = 1'b1;
        end
        step(2);
        chk("fp_owner1", 32'(own), 32'd1);
        chk("fp_addr1", 32'(baddr), 32'h44);
        ack_bus(32'h0);
        chk("fp_ack1", 32'(ack), 32'h2);
        req = 2'b00;
        step(1);
        chk("fp_ack_drop", 32'(ack), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
Shares the single internal register bus between two masters. Master 0 is the uP interface. Master 1 is the on-chip motion sequencer (PID/profile engine, next block). The slaves (QE and PWM channels) see exactly one transaction at a time. The block does request arbitration, bus sequencing with a 4-phase handshake back to each master, and a bus-timeout watchdog.

Parameters:
ADDR_W, 8, register address width
DATA_W, 32, register data width
TIMEOUT_CYCLES, 255, clk cycles to wait for bus_ack before aborting (1..2^16-1)
FIXED_PRIORITY, 0, 0 = round-robin; 1 = master 0 always wins

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  asynchronous, active-high reset
m_req  in  2  per-master request; held high until m_ack seen
m_rw  in  2  per-master direction, 1 = read, 0 = write; stable while m_req high
m_addr  in  2xADDR_W  per-master register address; stable while m_req high
m_wdata  in  2xDATA_W  per-master write data; stable while m_req high
m_ack  out  2  per-master completion; held until that m_req falls
m_err  out  2  per-master timeout flag; valid while m_ack high
m_rdata  out  DATA_W  read data captured from slave; valid while m_ack high
bus_valid  out  1  transaction active on slave side
bus_rw  out  1  direction to slaves
bus_addr  out  ADDR_W  address to slaves
bus_wdata  out  DATA_W  write data to slaves
bus_ack  in  1  any slave completion (OR of slave acks); one or more cycles
bus_rdata  in  DATA_W  read data, valid with bus_ack
owner  out  1  index of current/last granted master (debug/test point)

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, rr pointer = 0, timeout counter = 0.
- States: IDLE -> ISSUE -> WAIT_ACK -> RELEASE -> IDLE.
- IDLE: if any m_req is high, select a winner and register owner, then go to ISSUE. The winner's rw/addr/wdata are latched into the bus_* registers.
  - Arbitration, round-robin: the master other than last-served wins ties.
  - Arbitration, FIXED_PRIORITY=1: master 0 wins ties.
  - A single requester always wins.
- ISSUE: bus_valid=1 (first cycle with bus_valid is 2 clk after m_req rises into IDLE). Counter cleared. Go to WAIT_ACK.
- WAIT_ACK: bus_valid held, bus_* stable, counter increments each cycle.
  - bus_ack=1: capture bus_rdata into m_rdata (writes capture too; value is don't-care), m_ack[owner]=1, m_err[owner]=0, bus_valid=0 the next cycle, go to RELEASE.
  - Counter reaches TIMEOUT_CYCLES with no bus_ack: bus_valid=0, m_rdata=0, m_ack[owner]=1, m_err[owner]=1, go to RELEASE.
  - bus_ack and timeout in the same cycle: bus_ack wins (no error).
- RELEASE: hold m_ack/m_err/m_rdata until m_req[owner]=0. Then m_ack/m_err drop, the rr pointer advances past owner, and the state goes to IDLE. The next arbitration earliest 1 cycle later.
  - The other master's request stays pending throughout and is never dropped.
- bus_ack seen in IDLE/ISSUE/RELEASE: ignored.
- m_req of the non-owner rising or falling mid-transaction: no effect on the current transaction.
- m_req[owner] dropping before m_ack (protocol violation): the transaction still completes on the bus. RELEASE then exits immediately; m_ack pulses for 1 cycle.
- Reset mid-transaction: bus_valid drops asynchronously; no ack is issued.
- Throughput: one transaction per (4 + slave latency) cycles minimum.

Decomposition:
- types package gains:
  - enum arb_state_t {IDLE, ISSUE, WAIT_ACK, RELEASE}
  - typedef master_id_t (logic [0:0])
- global_constants gains `NOS_BUS_MASTERS (2) and `BUS_TIMEOUT_DEFAULT (255).
- One sub-module: rr_select. It is a combinational plus pointer-register 2-way round-robin/fixed-priority chooser (inputs req, last, fixed; output grant_id, any). It is reused later when NOS_BUS_MASTERS grows.

Test Plan:
- Write: m_req[0]=1, rw=0, addr=0x12, wdata=0xDEADBEEF; slave acks after 3 cycles -> bus_addr=0x12 and bus_wdata=0xDEADBEEF while bus_valid; m_ack[0]=1, m_err[0]=0; ack held until m_req[0] falls.
- Read: m_req[1], rw=1, addr=0x05; slave returns 0x0000_1234 with bus_ack -> m_rdata=0x00001234, m_ack[1]=1, owner=1.
- Simultaneous requests repeated 4 times, FIXED_PRIORITY=0 -> grants alternate 0,1,0,1. With FIXED_PRIORITY=1 and master 0 re-requesting immediately -> master 0 served first each time; master 1 served only when m_req[0] is low in IDLE.
- Timeout: no bus_ack, TIMEOUT_CYCLES=10 -> bus_valid drops exactly 10 cycles after WAIT_ACK entry; m_ack=1, m_err=1, m_rdata=0.
- bus_ack asserted on the timeout cycle -> m_err=0, rdata captured.
- Reset asserted during WAIT_ACK -> bus_valid, m_ack, m_err go 0 immediately. After release, a pending m_req is re-arbitrated from master 0 pointer.
